// File: rtl/dft_ctrl_pkg.sv
// dft_ctrl_pkg: shared types and defaults for the DFT sequencer
package dft_ctrl_pkg;
    localparam int DFT_ROWS    = 32;
    localparam int DFT_SW      = 16;
    localparam int DFT_TIMEOUT = 4096;
    typedef enum logic [2:0] {IDLE, PULSE, FEED, WAIT, CAPTURE, DONE} state_t;
    typedef logic [3:0][DFT_SW-1:0] row_t;
endpackage

// File: rtl/dft_seq_ctrl_if.sv
// dft_seq_ctrl_if: host buffer access, status and DFT core stream signals
interface dft_seq_ctrl_if import dft_ctrl_pkg::*; #(
    parameter int ROWS = DFT_ROWS,
    parameter int SW   = DFT_SW
) ();
    localparam int AW = $clog2(ROWS);
    logic            start;
    logic            x_we;
    logic [AW-1:0]   x_addr;
    logic [4*SW-1:0] x_wdata;
    logic [AW-1:0]   y_addr;
    logic [4*SW-1:0] y_rdata;
    logic            busy;
    logic            done;
    logic            timeout;
    logic            wr_err;
    logic            core_next;
    logic [SW-1:0]   core_x0, core_x1, core_x2, core_x3;
    logic [SW-1:0]   core_y0, core_y1, core_y2, core_y3;
    logic            core_next_out;
    modport master (
        output start, x_we, x_addr, x_wdata, y_addr,
        output core_y0, core_y1, core_y2, core_y3, core_next_out,
        input  y_rdata, busy, done, timeout, wr_err,
        input  core_next, core_x0, core_x1, core_x2, core_x3
    );
    modport slave (
        input  start, x_we, x_addr, x_wdata, y_addr,
        input  core_y0, core_y1, core_y2, core_y3, core_next_out,
        output y_rdata, busy, done, timeout, wr_err,
        output core_next, core_x0, core_x1, core_x2, core_x3
    );
endinterface

// File: rtl/dft_row_buf.sv
// dft_row_buf: simple dual-port row buffer with a registered read port
module dft_row_buf import dft_ctrl_pkg::*; #(
    parameter int DEPTH = DFT_ROWS,
    parameter int W     = 4 * DFT_SW,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];
    // contents survive reset; only the read register clears
    always_ff @(posedge clk) begin
        if (we && rst_n) mem[waddr] <= wdata;
        rdata <= rst_n ? mem[raddr] : '0;
    end
endmodule

// File: rtl/dft_seq_ctrl.sv
// dft_seq_ctrl: streams buffered rows into the DFT core and captures its output rows
module dft_seq_ctrl import dft_ctrl_pkg::*; #(
    parameter int ROWS    = DFT_ROWS,
    parameter int SW      = DFT_SW,
    parameter int TIMEOUT = DFT_TIMEOUT
) (
    input logic           clk,
    input logic           rst_n,
    dft_seq_ctrl_if.slave bus
);
    localparam int AW = $clog2(ROWS);
    localparam int TW = $clog2(TIMEOUT);
    localparam int RW = 4 * SW;
    state_t        state, state_nx;
    logic [AW-1:0] cnt, cnt_nx, x_raddr;
    logic [TW-1:0] tcnt;
    logic [RW-1:0] x_row;
    logic          idle, go, done_q, timeout_q, wr_err_q;
    assign idle = state == IDLE || state == DONE;
    assign go   = bus.start && idle;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            tcnt      <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            tcnt      <= state == WAIT ? tcnt + 1'b1 : '0;
            done_q    <= !go && (done_q || state_nx == DONE);
            timeout_q <= !go && (timeout_q || (state == WAIT && state_nx == DONE));
            wr_err_q  <= !go && (wr_err_q || (bus.x_we && !idle));
        end
    end
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE, DONE: state_nx = go ? PULSE : state;
            PULSE: begin
                state_nx = FEED;
                cnt_nx   = '0;
            end
            FEED: begin
                cnt_nx   = cnt + 1'b1;
                state_nx = cnt == AW'(ROWS - 1) ? WAIT : FEED;
            end
            WAIT: begin
                cnt_nx   = '0;
                state_nx = bus.core_next_out ? CAPTURE : tcnt == TW'(TIMEOUT - 1) ? DONE : WAIT;
            end
            CAPTURE: begin
                cnt_nx   = cnt + 1'b1;
                state_nx = cnt == AW'(ROWS - 1) ? DONE : CAPTURE;
            end
            default: state_nx = IDLE;
        endcase
    end
    // read one row ahead so row k is on the core inputs in FEED cycle k
    assign x_raddr = state == PULSE ? '0 : cnt + 1'b1;
    dft_row_buf #(.DEPTH(ROWS), .W(RW)) u_xbuf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (bus.x_we && idle),
        .waddr (bus.x_addr),
        .wdata (bus.x_wdata),
        .raddr (x_raddr),
        .rdata (x_row)
    );
    dft_row_buf #(.DEPTH(ROWS), .W(RW)) u_ybuf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (state == CAPTURE),
        .waddr (cnt),
        .wdata ({bus.core_y3, bus.core_y2, bus.core_y1, bus.core_y0}),
        .raddr (bus.y_addr),
        .rdata (bus.y_rdata)
    );
    assign bus.busy      = !idle;
    assign bus.done      = done_q;
    assign bus.timeout   = timeout_q;
    assign bus.wr_err    = wr_err_q;
    assign bus.core_next = state == PULSE;
    assign bus.core_x0   = state == FEED ? x_row[0*SW +: SW] : '0;
    assign bus.core_x1   = state == FEED ? x_row[1*SW +: SW] : '0;
    assign bus.core_x2   = state == FEED ? x_row[2*SW +: SW] : '0;
    assign bus.core_x3   = state == FEED ? x_row[3*SW +: SW] : '0;
endmodule
